// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer
// Turns one handshaked command (hold, shift toward bit 0, shift toward bit 3,
// or parallel load) into the per-cycle Select/SerialIn/Block drive of a
// downstream universal shift register. It also keeps a mirror of that
// register's contents.

module shift_reg_sequencer #(
  parameter int REG_W  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [1:0]        CmdOp,
  input  logic [DATA_W-1:0] CmdData,
  input  logic [CNT_W-1:0]  CmdCount,
  output logic [1:0]        Select,
  output logic              SerialIn,
  output logic [REG_W-1:0]  Block,
  output logic              Busy,
  output logic              Done,
  output logic [REG_W-1:0]  Mirror
);

  // Operation encoding shared with the downstream Select input.
  localparam logic [1:0] OP_HOLD = 2'b00;  // keep contents
  localparam logic [1:0] OP_SHR  = 2'b01;  // shift toward bit 0, insert at top
  localparam logic [1:0] OP_SHL  = 2'b10;  // shift toward top, insert at bit 0
  localparam logic [1:0] OP_LOAD = 2'b11;  // parallel load from Block

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of EXEC cycles a command needs. A load always takes one cycle.
  // Shifts are limited to the number of data bits available. A hold uses
  // the count as given.
  function automatic logic [CNT_W-1:0] eff_count(input logic [1:0]       op,
                                                 input logic [CNT_W-1:0] count);
    logic [CNT_W-1:0] n;
    case (op)
      OP_LOAD: n = CNT_ONE;
      OP_SHR, OP_SHL: begin
        if (int'(count) > DATA_W) begin
          n = CNT_W'(DATA_W);
        end else begin
          n = count;
        end
      end
      OP_HOLD: n = count;
      default: n = count;
    endcase
    return n;
  endfunction

  state_t              state_q;
  logic [1:0]          op_q;        // captured operation
  logic [DATA_W-1:0]   data_q;      // serial bits still to be sent, LSB next
  logic [CNT_W-1:0]    cnt_q;       // EXEC cycles remaining after the current one
  logic [1:0]          select_q;
  logic                serial_q;
  logic [REG_W-1:0]    block_q;
  logic                done_q;
  logic [REG_W-1:0]    mirror_q;
  logic [REG_W-1:0]    mirror_d;
  logic [CNT_W-1:0]    n_s;

  assign n_s = eff_count(CmdOp, CmdCount);

  // Command FSM: acceptance, cycle counting and all registered drive outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_HOLD;
      data_q   <= {DATA_W{1'b0}};
      cnt_q    <= CNT_ZERO;
      select_q <= OP_HOLD;
      serial_q <= 1'b0;
      block_q  <= {REG_W{1'b0}};
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (CmdValid) begin
            op_q <= CmdOp;
            if (n_s != CNT_ZERO) begin
              // The first bit goes out immediately. The rest wait in data_q.
              state_q  <= ST_EXEC;
              select_q <= CmdOp;
              serial_q <= CmdData[0];
              data_q   <= {1'b0, CmdData[DATA_W-1:1]};
              cnt_q    <= n_s - CNT_ONE;
              block_q  <= (CmdOp == OP_LOAD) ? CmdData[REG_W-1:0] : {REG_W{1'b0}};
            end else begin
              // Zero-length command: go straight to completion.
              state_q  <= ST_DONE;
              select_q <= OP_HOLD;
              serial_q <= 1'b0;
              block_q  <= {REG_W{1'b0}};
              data_q   <= {DATA_W{1'b0}};
              cnt_q    <= CNT_ZERO;
              done_q   <= 1'b1;
            end
          end else begin
            state_q  <= ST_IDLE;
            select_q <= OP_HOLD;
            serial_q <= 1'b0;
            block_q  <= {REG_W{1'b0}};
          end
        end

        ST_EXEC: begin
          if (cnt_q == CNT_ZERO) begin
            state_q  <= ST_DONE;
            select_q <= OP_HOLD;
            serial_q <= 1'b0;
            block_q  <= {REG_W{1'b0}};
            done_q   <= 1'b1;
          end else begin
            // Another cycle of the same op, with the next data bit.
            state_q  <= ST_EXEC;
            cnt_q    <= cnt_q - CNT_ONE;
            select_q <= op_q;
            serial_q <= data_q[0];
            data_q   <= {1'b0, data_q[DATA_W-1:1]};
            block_q  <= {REG_W{1'b0}};
            done_q   <= 1'b0;
          end
        end

        ST_DONE: begin
          state_q  <= ST_IDLE;
          select_q <= OP_HOLD;
          serial_q <= 1'b0;
          block_q  <= {REG_W{1'b0}};
          done_q   <= 1'b0;
        end

        default: begin
          state_q  <= ST_IDLE;
          select_q <= OP_HOLD;
          serial_q <= 1'b0;
          block_q  <= {REG_W{1'b0}};
          done_q   <= 1'b0;
          cnt_q    <= CNT_ZERO;
        end
      endcase
    end
  end

  // Next mirror value: what the downstream register loads at the coming edge.
  always_comb begin
    mirror_d = mirror_q;
    case (select_q)
      OP_SHR:  mirror_d = {serial_q, mirror_q[REG_W-1:1]};
      OP_SHL:  mirror_d = {mirror_q[REG_W-2:0], serial_q};
      OP_LOAD: mirror_d = block_q;
      OP_HOLD: mirror_d = mirror_q;
      default: mirror_d = mirror_q;
    endcase
  end

  // Mirror register. It clears with the same reset as the downstream register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mirror_q <= {REG_W{1'b0}};
    end else begin
      mirror_q <= mirror_d;
    end
  end

  assign CmdReady = (state_q == ST_IDLE);
  assign Busy     = (state_q != ST_IDLE);
  assign Select   = select_q;
  assign SerialIn = serial_q;
  assign Block    = block_q;
  assign Done     = done_q;
  assign Mirror   = mirror_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer. Every expected value is hand-derived.
module tb_shift_reg_sequencer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       CmdValid;
  logic       CmdReady;
  logic [1:0] CmdOp;
  logic [7:0] CmdData;
  logic [3:0] CmdCount;
  logic [1:0] Select;
  logic       SerialIn;
  logic [3:0] Block;
  logic       Busy;
  logic       Done;
  logic [3:0] Mirror;

  int checks = 0;
  int failures = 0;

  shift_reg_sequencer #(.REG_W(4), .DATA_W(8), .CNT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdData(CmdData), .CmdCount(CmdCount),
    .Select(Select), .SerialIn(SerialIn), .Block(Block),
    .Busy(Busy), .Done(Done), .Mirror(Mirror)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock; sample 1 time unit after the rising edge
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic [3:0] cnt);
    CmdValid = 1'b1; CmdOp = op; CmdData = data; CmdCount = cnt;
    step();
    CmdValid = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_m[4];
    logic       exp_s[8];

    Reset = 1'b1; CmdValid = 1'b0; CmdOp = 2'b00; CmdData = 8'h00; CmdCount = 4'd0;
    #2;
    chk("rst_ready", CmdReady, 1);
    chk("rst_select", Select, 0);
    chk("rst_serial", SerialIn, 0);
    chk("rst_block", Block, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_mirror", Mirror, 0);
    step();
    Reset = 1'b0;

    // ---- parallel load A5 ----
    issue(2'b11, 8'hA5, 4'd9);
    chk("ld_select", Select, 2'b11);
    chk("ld_block", Block, 4'h5);
    chk("ld_busy", Busy, 1);
    chk("ld_ready", CmdReady, 0);
    chk("ld_mirror_pre", Mirror, 0);
    step();
    chk("ld_done", Done, 1);
    chk("ld_done_sel", Select, 0);
    chk("ld_done_blk", Block, 0);
    chk("ld_mirror", Mirror, 4'h5);
    step();
    chk("ld_idle_done", Done, 0);
    chk("ld_idle_ready", CmdReady, 1);
    chk("ld_idle_mirror", Mirror, 4'h5);

    // ---- shift toward bit 0, 0D, 4 cycles ----
    pulse_reset();
    chk("rst2_mirror", Mirror, 0);
    exp_s[0] = 1; exp_s[1] = 0; exp_s[2] = 1; exp_s[3] = 1;
    exp_m[0] = 4'h8; exp_m[1] = 4'h4; exp_m[2] = 4'hA; exp_m[3] = 4'hD;
    issue(2'b01, 8'h0D, 4'd4);
    for (int i = 0; i < 4; i++) begin
      chk("shr_select", Select, 2'b01);
      chk("shr_serial", SerialIn, exp_s[i]);
      chk("shr_done_low", Done, 0);
      step();
      chk("shr_mirror", Mirror, exp_m[i]);
    end
    chk("shr_done", Done, 1);
    chk("shr_done_sel", Select, 0);
    step();

    // ---- shift toward bit 3, 0D, 4 cycles ----
    pulse_reset();
    exp_m[0] = 4'h1; exp_m[1] = 4'h2; exp_m[2] = 4'h5; exp_m[3] = 4'hB;
    issue(2'b10, 8'h0D, 4'd4);
    for (int i = 0; i < 4; i++) begin
      chk("shl_select", Select, 2'b10);
      step();
      chk("shl_mirror", Mirror, exp_m[i]);
    end
    chk("shl_done", Done, 1);
    step();

    // ---- hold, 3 cycles ----
    issue(2'b00, 8'hFF, 4'd3);
    for (int i = 0; i < 3; i++) begin
      chk("hold_busy", Busy, 1);
      chk("hold_select", Select, 0);
      chk("hold_done_low", Done, 0);
      chk("hold_mirror", Mirror, 4'hB);
      step();
    end
    chk("hold_done", Done, 1);
    chk("hold_mirror_end", Mirror, 4'hB);
    step();

    // ---- clamped shift: count 15 -> 8 cycles, data F0 ----
    issue(2'b01, 8'hF0, 4'd15);
    for (int i = 0; i < 8; i++) begin
      chk("clamp_select", Select, 2'b01);
      chk("clamp_serial", SerialIn, (i >= 4) ? 1 : 0);
      step();
    end
    chk("clamp_done", Done, 1);
    chk("clamp_mirror", Mirror, 4'hF);
    step();

    // ---- zero-count shift ----
    issue(2'b10, 8'h55, 4'd0);
    chk("zero_done", Done, 1);
    chk("zero_select", Select, 0);
    chk("zero_busy", Busy, 1);
    chk("zero_mirror", Mirror, 4'hF);
    step();
    chk("zero_idle", CmdReady, 1);
    chk("zero_done_low", Done, 0);

    // ---- back-to-back with CmdValid held ----
    CmdValid = 1'b1; CmdOp = 2'b01; CmdData = 8'h03; CmdCount = 4'd2;
    step();                         // first accept
    CmdData = 8'hFC;                // ignored while busy
    chk("b2b_serial0", SerialIn, 1);
    chk("b2b_ready0", CmdReady, 0);
    step();
    chk("b2b_serial1", SerialIn, 1);
    chk("b2b_ready1", CmdReady, 0);
    step();
    chk("b2b_done", Done, 1);
    chk("b2b_ready2", CmdReady, 0);
    chk("b2b_mirror1", Mirror, 4'hF);
    step();
    chk("b2b_ready3", CmdReady, 1);
    CmdData = 8'h02;
    step();                         // second accept, 4 cycles after the first
    CmdValid = 1'b0;
    chk("b2b2_busy", Busy, 1);
    chk("b2b2_serial0", SerialIn, 0);
    step();
    chk("b2b2_serial1", SerialIn, 1);
    chk("b2b2_mirror_mid", Mirror, 4'h7);
    step();
    chk("b2b2_done", Done, 1);
    chk("b2b2_mirror", Mirror, 4'hB);
    step();

    // ---- reset in the middle of an 8-bit shift ----
    issue(2'b01, 8'hFF, 4'd8);
    step();
    step();                         // now in 3rd EXEC cycle
    chk("abort_pre_select", Select, 2'b01);
    Reset = 1'b1;
    #1;
    chk("abort_select", Select, 0);
    chk("abort_serial", SerialIn, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_ready", CmdReady, 1);
    chk("abort_mirror", Mirror, 0);
    step();
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_done", Done, 0);
      step();
    end
    chk("abort_mirror_hold", Mirror, 0);

    issue(2'b11, 8'h3C, 4'd0);
    chk("post_block", Block, 4'hC);
    step();
    chk("post_done", Done, 1);
    chk("post_mirror", Mirror, 4'hC);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
